// File: rtl/noc_packet_checker.sv
// noc_packet_checker: self-checking packet sink for a NoC local port.
// Accepts flits on a valid/ready interface, checks destination, framing, length and the
// body payload pattern of every packet, and keeps saturating statistics/error counters.
// Optional feature: define NOC_CHECKER_BP_EN to throttle receive_ready with a 16-bit LFSR;
// without it receive_ready rises on the first edge after reset and stays high.

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif

module noc_packet_checker #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID      = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID      = '0,
    parameter logic [15:0]                LFSR_SEED = 16'hACE1
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic                       receive_valid,
    output logic                       receive_ready,
    input  logic [`Noc_Data_Width-1:0] receive_flit,
    input  logic                       receive_is_header,
    input  logic                       receive_is_tail,
    input  logic                       clear_err,
    output logic [15:0]                pkt_count,
    output logic [31:0]                flit_count,
    output logic [15:0]                err_count,
    output logic                       err_flag,
    output logic [2:0]                 last_err_code,
    output logic                       busy
);

    localparam int unsigned DataWidth = `Noc_Data_Width;

    // Error codes; a flit with several faults reports the lowest one.
    localparam logic [2:0] ErrNone        = 3'd0;
    localparam logic [2:0] ErrDst         = 3'd1;
    localparam logic [2:0] ErrHeader      = 3'd2;
    localparam logic [2:0] ErrEarlyTail   = 3'd3;
    localparam logic [2:0] ErrMissingTail = 3'd4;
    localparam logic [2:0] ErrPayload     = 3'd5;
    localparam logic [2:0] ErrLen         = 3'd6;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBody  = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e         state_q;
    state_e         state_d;
    logic [7:0]     len_q;
    logic [7:0]     seq_q;
    logic [7:0]     idx_q;      // index k of the next expected body flit, counts from 1

    logic           accept;
    logic           dst_match;
    logic [7:0]     hdr_len;
    logic [7:0]     hdr_seq;
    logic [DataWidth-1:0] body_exp;
    logic [2:0]     err_code;
    logic           pkt_ok;

    assign accept    = receive_valid && receive_ready;
    assign hdr_len   = receive_flit[23:16];
    assign hdr_seq   = receive_flit[31:24];
    assign dst_match = (receive_flit[3:0] == 4'(X_ID)) && (receive_flit[7:4] == 4'(Y_ID));

    // Expected body flit k: {zero-extend, seq, k, 16'hA5A5}.
    always_comb begin
        body_exp       = '0;
        body_exp[31:0] = {seq_q, idx_q, 16'hA5A5};
    end

    // Classify the flit on the interface against the current state; only used on accept.
    always_comb begin
        err_code = ErrNone;
        state_d  = state_q;
        pkt_ok   = 1'b0;
        case (state_q)
            StIdle: begin
                if (!receive_is_header) begin
                    err_code = ErrHeader;
                end else if (!dst_match) begin
                    err_code = ErrDst;
                end else if ((hdr_len == 8'd0) != receive_is_tail) begin
                    err_code = ErrLen;
                end

                if (err_code != ErrNone) begin
                    state_d = receive_is_tail ? StIdle : StDrain;
                end else if (hdr_len == 8'd0) begin
                    // Single-flit packet: header carries the tail.
                    pkt_ok  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StBody;
                end
            end
            StBody: begin
                if (receive_is_header) begin
                    err_code = ErrHeader;
                end else if (receive_is_tail && (idx_q < len_q)) begin
                    err_code = ErrEarlyTail;
                end else if ((idx_q == len_q) && !receive_is_tail) begin
                    err_code = ErrMissingTail;
                end else if (receive_flit != body_exp) begin
                    err_code = ErrPayload;
                end

                if (err_code != ErrNone) begin
                    state_d = receive_is_tail ? StIdle : StDrain;
                end else if (idx_q == len_q) begin
                    // Earlier errors would have left BODY, so reaching here means a clean packet.
                    pkt_ok  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StBody;
                end
            end
            StDrain: begin
                // Headers are discarded here too; only a tail ends the drain.
                if (receive_is_tail) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM, packet context, counters and sticky error status; all change only on accept
    // except clear_err, which a coincident new error overrides.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q       <= StIdle;
            len_q         <= 8'd0;
            seq_q         <= 8'd0;
            idx_q         <= 8'd0;
            busy          <= 1'b0;
            pkt_count     <= 16'd0;
            flit_count    <= 32'd0;
            err_count     <= 16'd0;
            err_flag      <= 1'b0;
            last_err_code <= 3'd0;
        end else begin
            if (clear_err) begin
                err_flag      <= 1'b0;
                last_err_code <= 3'd0;
            end

            if (accept) begin
                state_q <= state_d;
                busy    <= (state_d != StIdle);

                if ((state_q == StIdle) && (state_d == StBody)) begin
                    len_q <= hdr_len;
                    seq_q <= hdr_seq;
                    idx_q <= 8'd1;
                end else if (state_q == StBody) begin
                    idx_q <= idx_q + 8'd1;
                end

                if (flit_count != 32'hFFFF_FFFF) begin
                    flit_count <= flit_count + 32'd1;
                end

                if (pkt_ok && (pkt_count != 16'hFFFF)) begin
                    pkt_count <= pkt_count + 16'd1;
                end

                // Every error ends the packet's checking, so each one is its packet's first.
                if (err_code != ErrNone) begin
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                    err_flag      <= 1'b1;
                    last_err_code <= err_code;
                end
            end
        end
    end

`ifdef NOC_CHECKER_BP_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR (taps 16,14,13,11) advancing every cycle; ready ~75% of cycles.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            lfsr_q        <= LFSR_SEED;
            receive_ready <= 1'b0;
        end else begin
            lfsr_q        <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            receive_ready <= (lfsr_q[1:0] != 2'b00);
        end
    end
`else
    logic [15:0] unused_lfsr_seed;
    assign unused_lfsr_seed = LFSR_SEED;

    // Always ready once out of reset.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            receive_ready <= 1'b0;
        end else begin
            receive_ready <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_packet_checker.sv
// Scoreboard bench for noc_packet_checker: a packet-level reference model predicts the
// status outputs after every accepted flit or clear_err pulse; a monitor compares them.

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif

module tb_noc_packet_checker;

    localparam int DW = `Noc_Data_Width;
    localparam logic [3:0] XID = 4'd3;
    localparam logic [3:0] YID = 4'd5;

    logic          noc_clk;
    logic          noc_rst_n;
    logic          receive_valid;
    logic          receive_ready;
    logic [DW-1:0] receive_flit;
    logic          receive_is_header;
    logic          receive_is_tail;
    logic          clear_err;
    logic [15:0]   pkt_count;
    logic [31:0]   flit_count;
    logic [15:0]   err_count;
    logic          err_flag;
    logic [2:0]    last_err_code;
    logic          busy;

    noc_packet_checker #(
        .X_ID      (XID),
        .Y_ID      (YID),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .noc_clk           (noc_clk),
        .noc_rst_n         (noc_rst_n),
        .receive_valid     (receive_valid),
        .receive_ready     (receive_ready),
        .receive_flit      (receive_flit),
        .receive_is_header (receive_is_header),
        .receive_is_tail   (receive_is_tail),
        .clear_err         (clear_err),
        .pkt_count         (pkt_count),
        .flit_count        (flit_count),
        .err_count         (err_count),
        .err_flag          (err_flag),
        .last_err_code     (last_err_code),
        .busy              (busy)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    typedef struct packed {
        logic [15:0] pkt;
        logic [31:0] flit;
        logic [15:0] err;
        logic        flag;
        logic [2:0]  code;
        logic        busy;
    } snap_t;

    snap_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: packet-level view of what the checker should have seen so far.
    int     m_pkt, m_err, m_code;
    longint m_flit;
    bit     m_flag, m_in_pkt, m_drain;
    int     m_len, m_seq, m_k;

    task automatic model_reset();
        m_pkt = 0; m_err = 0; m_code = 0; m_flit = 0;
        m_flag = 0; m_in_pkt = 0; m_drain = 0;
        m_len = 0; m_seq = 0; m_k = 0;
    endtask

    function automatic logic [DW-1:0] body_word(input int seq, input int k);
        logic [DW-1:0] v;
        v = '0;
        v[31:0] = 32'(seq * 16777216 + k * 65536 + 'hA5A5);
        return v;
    endfunction

    function automatic logic [DW-1:0] mk_hdr(input int dx, input int dy, input int len,
                                             input int seq);
        logic [DW-1:0] v;
        v = '0;
        v[3:0]   = 4'(dx);
        v[7:4]   = 4'(dy);
        v[15:8]  = 8'($urandom);
        v[23:16] = 8'(len);
        v[31:24] = 8'(seq);
        return v;
    endfunction

    task automatic model_step(input logic [DW-1:0] f, input bit hdr, input bit tail,
                              input bit xfer, input bit clr);
        int code;
        snap_t s;
        code = 0;
        if (clr) begin
            m_flag = 0;
            m_code = 0;
        end
        if (xfer) begin
            if (m_flit < 64'hFFFF_FFFF) m_flit++;
            if (m_drain) begin
                if (tail) m_drain = 0;
            end else if (!m_in_pkt) begin
                if (!hdr) code = 2;
                else if (int'(f[3:0]) != int'(XID) || int'(f[7:4]) != int'(YID)) code = 1;
                else if ((f[23:16] == 8'd0) != tail) code = 6;
                if (code != 0) begin
                    if (!tail) m_drain = 1;
                end else if (f[23:16] == 8'd0) begin
                    if (m_pkt < 65535) m_pkt++;
                end else begin
                    m_in_pkt = 1;
                    m_k = 1;
                    m_len = int'(f[23:16]);
                    m_seq = int'(f[31:24]);
                end
            end else begin
                if (hdr) code = 2;
                else if (tail && m_k < m_len) code = 3;
                else if (m_k == m_len && !tail) code = 4;
                else if (f != body_word(m_seq, m_k)) code = 5;
                if (code != 0) begin
                    m_in_pkt = 0;
                    if (!tail) m_drain = 1;
                end else if (m_k == m_len) begin
                    m_in_pkt = 0;
                    if (m_pkt < 65535) m_pkt++;
                end else begin
                    m_k++;
                end
            end
            if (code != 0) begin
                if (m_err < 65535) m_err++;
                m_flag = 1;
                m_code = code;
            end
        end
        s.pkt  = 16'(m_pkt);
        s.flit = 32'(m_flit);
        s.err  = 16'(m_err);
        s.flag = m_flag;
        s.code = 3'(m_code);
        s.busy = m_in_pkt || m_drain;
        exp_q.push_back(s);
    endtask

    // Monitor: an accepted flit or clear_err at a rising edge is an output event.
    initial begin
        bit    ev;
        snap_t act;
        snap_t exp;
        forever begin
            @(posedge noc_clk);
            ev = noc_rst_n && ((receive_valid && receive_ready) || clear_err);
            @(negedge noc_clk);
            if (ev) begin
                act = '{pkt_count, flit_count, err_count, err_flag, last_err_code, busy};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got %p, required nothing", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        miscompares++;
                        $display("FAIL status at %0t: got %p, required %p", $time, act, exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] f, input bit hdr, input bit tail,
                        input bit clr = 1'b0);
        int n;
        n = 0;
        @(negedge noc_clk);
        receive_valid     = 1'b1;
        receive_flit      = f;
        receive_is_header = hdr;
        receive_is_tail   = tail;
        while (!receive_ready && n < 64) begin
            @(negedge noc_clk);
            n++;
        end
        if (!receive_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got ready 0 for %0d cycles, required 1", n);
            receive_valid = 1'b0;
            return;
        end
        clear_err = clr;
        model_step(f, hdr, tail, 1'b1, clr);
        @(posedge noc_clk);
        #1;
        receive_valid = 1'b0;
        clear_err     = 1'b0;
    endtask

    task automatic clear_pulse();
        @(negedge noc_clk);
        clear_err = 1'b1;
        model_step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge noc_clk);
        #1;
        clear_err = 1'b0;
    endtask

    task automatic good_pkt(input int len, input int seq);
        send(mk_hdr(XID, YID, len, seq), 1'b1, len == 0);
        for (int k = 1; k <= len; k++) send(body_word(seq, k), 1'b0, k == len);
    endtask

    // Asserts reset off-edge (optionally mid-transfer), checks reset values at once.
    task automatic do_reset(input bit hold_valid);
        repeat (2) @(negedge noc_clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        receive_valid     = hold_valid;
        receive_flit      = body_word(m_seq, m_k);
        receive_is_header = 1'b0;
        receive_is_tail   = 1'b0;
        #2;
        noc_rst_n = 1'b0;
        #1;
        chk("rst_ready", receive_ready, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_flit_count", flit_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_last_err_code", last_err_code, 0);
        chk("rst_busy", busy, 0);
        receive_valid = 1'b1;
        repeat (3) @(negedge noc_clk);
        receive_valid = 1'b0;
        chk("no_xfer_in_reset", flit_count, 0);
        model_reset();
        exp_q.delete();
        noc_rst_n = 1'b1;
    endtask

    task automatic random_pkt();
        int kind, len, seq, bad;
        logic [DW-1:0] w;
        kind = $urandom_range(0, 7);
        len  = $urandom_range(0, 5);
        seq  = $urandom_range(0, 255);
        case (kind)
            0, 1: good_pkt(len, seq);
            2: begin
                if ($urandom_range(0, 1) == 0)
                    send(mk_hdr(XID + $urandom_range(1, 15), YID, len, seq), 1'b1, len == 0);
                else
                    send(mk_hdr(XID, YID + $urandom_range(1, 15), len, seq), 1'b1, len == 0);
                for (int k = 1; k <= len; k++) send(body_word(seq, k), 1'b0, k == len);
            end
            3: begin
                send(mk_hdr(XID, YID, len, seq), 1'b1, len != 0);
                if (len == 0) send(32'($urandom), 1'b0, 1'b1);
            end
            4: begin
                len = (len < 2) ? 2 : len;
                bad = $urandom_range(1, len - 1);
                send(mk_hdr(XID, YID, len, seq), 1'b1, 1'b0);
                for (int k = 1; k <= bad; k++) send(body_word(seq, k), 1'b0, k == bad);
            end
            5: begin
                len = (len < 1) ? 1 : len;
                send(mk_hdr(XID, YID, len, seq), 1'b1, 1'b0);
                for (int k = 1; k <= len; k++) send(body_word(seq, k), 1'b0, 1'b0);
                send(32'($urandom), 1'b0, 1'b1);
            end
            6: begin
                len = (len < 1) ? 1 : len;
                bad = $urandom_range(1, len);
                send(mk_hdr(XID, YID, len, seq), 1'b1, 1'b0);
                for (int k = 1; k <= len; k++) begin
                    w = body_word(seq, k);
                    if (k == bad) w[$urandom_range(0, 31)] ^= 1'b1;
                    send(w, 1'b0, k == len);
                end
            end
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    send(32'($urandom), 1'b0, $urandom_range(0, 1) == 1);
                end else begin
                    len = (len < 2) ? 2 : len;
                    send(mk_hdr(XID, YID, len, seq), 1'b1, 1'b0);
                    send(body_word(seq, 1), 1'b0, 1'b0);
                    send(mk_hdr(XID, YID, 1, seq), 1'b1, 1'b0);
                    send(body_word(seq, 2), 1'b0, 1'b1);
                end
            end
        endcase
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        noc_rst_n         = 1'b0;
        receive_valid     = 1'b0;
        receive_flit      = '0;
        receive_is_header = 1'b0;
        receive_is_tail   = 1'b0;
        clear_err         = 1'b0;
        model_reset();
        #2;
        chk("init_ready", receive_ready, 0);
        chk("init_pkt_count", pkt_count, 0);
        chk("init_flit_count", flit_count, 0);
        chk("init_err_flag", err_flag, 0);
        chk("init_busy", busy, 0);
        #10;
        noc_rst_n = 1'b1;
        @(posedge noc_clk);
        #1;
`ifndef NOC_CHECKER_BP_EN
        chk("ready_after_reset", receive_ready, 1);
`endif

        // Clean 3-body packet.
        good_pkt(3, 8'h07);
        chk("t1_pkt_count", pkt_count, 1);
        chk("t1_flit_count", flit_count, 4);
        chk("t1_err_flag", err_flag, 0);

        // Wrong dst_x: error 1, bodies drained through the tail.
        send(mk_hdr(XID + 1, YID, 2, 8'h09), 1'b1, 1'b0);
        chk("t2_busy_drain", busy, 1);
        send(body_word(8'h09, 1), 1'b0, 1'b0);
        send(body_word(8'h09, 2), 1'b0, 1'b1);
        chk("t2_err_count", err_count, 1);
        chk("t2_code", last_err_code, 1);
        chk("t2_pkt_count", pkt_count, 1);
        chk("t2_busy", busy, 0);

        // Early tail on body 2 of 3, then a clean packet.
        send(mk_hdr(XID, YID, 3, 8'h10), 1'b1, 1'b0);
        send(body_word(8'h10, 1), 1'b0, 1'b0);
        send(body_word(8'h10, 2), 1'b0, 1'b1);
        chk("t3_code", last_err_code, 3);
        chk("t3_busy", busy, 0);
        good_pkt(1, 8'h11);
        chk("t3_pkt_count", pkt_count, 2);

        // Payload mismatch on body 2, drain, then clear_err.
        send(mk_hdr(XID, YID, 3, 8'h22), 1'b1, 1'b0);
        send(body_word(8'h22, 1), 1'b0, 1'b0);
        send(32'h2202A5A4, 1'b0, 1'b0);
        chk("t4_code", last_err_code, 5);
        send(body_word(8'h22, 3), 1'b0, 1'b1);
        clear_pulse();
        chk("t4_flag_cleared", err_flag, 0);
        chk("t4_err_count", err_count, 3);

        // clear_err coincident with a new error (stray body in IDLE): error wins.
        send(32'h12345678, 1'b0, 1'b1, 1'b1);
        chk("t5_flag", err_flag, 1);
        chk("t5_code", last_err_code, 2);

        // Header with dst mismatch and len/tail inconsistency reports the lower code.
        send(mk_hdr(XID + 1, YID, 0, 8'h33), 1'b1, 1'b0);
        send(32'h0, 1'b0, 1'b1);
        chk("t6_code", last_err_code, 1);

        for (int i = 0; i < 300; i++) begin
            random_pkt();
            repeat ($urandom_range(0, 2)) @(negedge noc_clk);
            if ($urandom_range(0, 9) == 0) clear_pulse();
        end

        // Reset in the middle of a packet while a flit is offered.
        send(mk_hdr(XID, YID, 3, 8'h44), 1'b1, 1'b0);
        send(body_word(8'h44, 1), 1'b0, 1'b0);
        chk("mid_busy", busy, 1);
        do_reset(1'b1);
        send(body_word(8'h44, 2), 1'b0, 1'b0);
        send(body_word(8'h44, 3), 1'b0, 1'b1);
        chk("post_rst_code", last_err_code, 2);
        good_pkt(2, 8'h45);
        chk("post_rst_pkt_count", pkt_count, 1);

        // Saturation of pkt_count with single-flit packets.
        do_reset(1'b0);
        for (int i = 0; i < 70000; i++) send(mk_hdr(XID, YID, 0, i), 1'b1, 1'b1);
        chk("sat_pkt_count", pkt_count, 16'hFFFF);
        chk("sat_flit_count", flit_count, 70000);

        repeat (2) @(negedge noc_clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
